// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared widths, screen geometry and spawn FSM states for the enemy spawner
package enemy_pkg;

  localparam int X_W              = 10;
  localparam int Y_W              = 10;
  localparam int SCREEN_W         = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  typedef enum logic {
    IDLE,
    ADVANCE
  } spawn_state_t;

endpackage

// File: rtl/lowest_free_sel.sv
// rtl/lowest_free_sel.sv - lowest-index priority select over a free-slot mask
module lowest_free_sel #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  free,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the top so the last hit, the lowest index, wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_spawner.sv
// rtl/enemy_spawner.sv - consumes generator x values, spawns enemies into a slot table and moves them per frame
module enemy_spawner
  import enemy_pkg::*;
#(
  parameter int N_SLOTS      = 4,
  parameter int SPAWN_FRAMES = 60,
  parameter int SPEED        = 2,
  parameter int SCREEN_H     = SCREEN_H_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     spawn_en,
  input  logic [X_W-1:0]           x_in,
  input  logic [N_SLOTS-1:0]       kill,
  output logic                     next,
  output logic [N_SLOTS-1:0]       active,
  output logic [N_SLOTS*X_W-1:0]   enemy_x,
  output logic [N_SLOTS*Y_W-1:0]   enemy_y
);

  localparam int TW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int YN = Y_W + 1;

  spawn_state_t                  state_q, state_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic                          pending_q, pending_d;
  logic [N_SLOTS-1:0]            active_q, active_d;
  logic [N_SLOTS-1:0][X_W-1:0]   x_q, x_d;
  logic [N_SLOTS-1:0][Y_W-1:0]   y_q, y_d;
  logic [YN-1:0]                 y_new;
  logic                          free_found;
  logic [IW-1:0]                 free_idx;
  logic                          spawn;
  logic                          expire;

  lowest_free_sel #(
    .N (N_SLOTS)
  ) u_sel (
    .free  (~active_q),
    .found (free_found),
    .idx   (free_idx)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    active_d  = active_q;
    x_d       = x_q;
    y_d       = y_q;
    y_new     = '0;
    expire    = 1'b0;
    // Spawning is blocked in ADVANCE so x_in is never read before the generator steps.
    spawn     = (state_q == IDLE) && pending_q && free_found;

    if (frame_tick && spawn_en) begin
      if (timer_q == TW'(SPAWN_FRAMES - 1)) begin
        timer_d = '0;
        expire  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (spawn)  pending_d = 1'b0;
    if (expire) pending_d = 1'b1;

    case (state_q)
      IDLE:    if (spawn) state_d = ADVANCE;
      ADVANCE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < N_SLOTS; i++) begin
      if (active_q[i]) begin
        if (kill[i]) begin
          active_d[i] = 1'b0;
        end else if (frame_tick) begin
          // 11-bit sum so a y near 1023 cannot wrap back on screen.
          y_new = {1'b0, y_q[i]} + YN'(SPEED);
          if (y_new >= YN'(SCREEN_H)) active_d[i] = 1'b0;
          else                        y_d[i]      = y_new[Y_W-1:0];
        end
      end else if (spawn && (free_idx == IW'(i))) begin
        active_d[i] = 1'b1;
        x_d[i]      = x_in;
        y_d[i]      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
      active_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign next    = (state_q == ADVANCE);
  assign active  = active_q;
  assign enemy_x = x_q;
  assign enemy_y = y_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// tb/tb_enemy_spawner.sv - scoreboard bench: expected spawns queued by stimulus, checked on each next pulse
module tb_enemy_spawner;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        spawn_en;
  logic [9:0]  x_in;
  logic [3:0]  kill;
  logic        next;
  logic [3:0]  active;
  logic [39:0] enemy_x;
  logic [39:0] enemy_y;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         slot;
    logic [9:0] x;
  } exp_t;

  exp_t exp_q[$];

  always #10 clk = ~clk;

  enemy_spawner #(
    .N_SLOTS      (4),
    .SPAWN_FRAMES (3),
    .SPEED        (2),
    .SCREEN_H     (480)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .spawn_en   (spawn_en),
    .x_in       (x_in),
    .kill       (kill),
    .next       (next),
    .active     (active),
    .enemy_x    (enemy_x),
    .enemy_y    (enemy_y)
  );

  function automatic logic [9:0] ex(int i);
    return enemy_x[i*10 +: 10];
  endfunction

  function automatic logic [9:0] ey(int i);
    return enemy_y[i*10 +: 10];
  endfunction

  task automatic chk(string name, logic [39:0] act, logic [39:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every next pulse must match the oldest queued spawn.
  logic prev_next = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (next === 1'b1) begin
      chk("next_single_cycle", {39'd0, prev_next}, 40'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_next: got pulse expected none");
      end else begin
        e = exp_q.pop_front();
        chk("spawn_active", {39'd0, active[e.slot]}, 40'd1);
        chk("spawn_x", {30'd0, ex(e.slot)}, {30'd0, e.x});
        chk("spawn_y", {30'd0, ey(e.slot)}, 40'd0);
      end
    end
    prev_next = next;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic push(int slot, logic [9:0] x);
    exp_t e;
    e.slot = slot;
    e.x    = x;
    exp_q.push_back(e);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; spawn_en = 1'b0; x_in = '0; kill = '0;
    idle(2);
    @(negedge clk);
    chk("rst_next",    {39'd0, next},   40'd0);
    chk("rst_active",  {36'd0, active}, 40'd0);
    chk("rst_enemy_x", enemy_x,         40'd0);
    chk("rst_enemy_y", enemy_y,         40'd0);
    cyc();
    reset = 1'b0;

    // First spawn after three ticks.
    spawn_en = 1'b1; x_in = 10'd99;
    push(0, 10'd99);
    ticks(3);
    idle(4);
    spawn_en = 1'b0;
    idle(10);
    @(negedge clk);
    chk("first_active", {36'd0, active}, 40'd1);
    chk("first_x0",     {30'd0, ex(0)},  40'd99);

    // Movement down to the bottom edge.
    ticks(239);
    @(negedge clk);
    chk("move_active_478", {39'd0, active[0]}, 40'd1);
    chk("move_y_478",      {30'd0, ey(0)},     40'd478);
    ticks(1);
    @(negedge clk);
    chk("retire_active", {39'd0, active[0]}, 40'd0);
    chk("retire_y_held", {30'd0, ey(0)},     40'd478);

    // Fill all four slots.
    spawn_en = 1'b1;
    x_in = 10'd10; push(0, 10'd10); ticks(3); idle(2);
    x_in = 10'd20; push(1, 10'd20); ticks(3); idle(2);
    x_in = 10'd30; push(2, 10'd30); ticks(3); idle(2);
    x_in = 10'd40; push(3, 10'd40); ticks(3); idle(2);
    @(negedge clk);
    chk("full_active",  {36'd0, active}, 40'd15);
    chk("full_enemy_x", enemy_x, {10'd40, 10'd30, 10'd20, 10'd10});
    chk("full_enemy_y", enemy_y, {10'd0, 10'd6, 10'd12, 10'd18});

    // Expiry with the table full: request waits, no pulse.
    ticks(3);
    idle(5);
    @(negedge clk);
    chk("full_wait_active", {36'd0, active}, 40'd15);
    chk("full_wait_y0",     {30'd0, ey(0)},  40'd24);

    // Kill slot 2; respawn lands there in the same cycle as a frame tick.
    x_in = 10'd55; push(2, 10'd55);
    kill = 4'b0100;
    cyc();
    kill = 4'b0000; frame_tick = 1'b1;
    @(negedge clk);
    chk("kill_frees_slot", {36'd0, active}, 40'd11);
    cyc();
    frame_tick = 1'b0;
    @(negedge clk);
    chk("respawn_next",   {39'd0, next},   40'd1);
    chk("respawn_active", {36'd0, active}, 40'd15);
    chk("collide_enemy_y", enemy_y, {10'd8, 10'd0, 10'd20, 10'd26});
    idle(2);

    // Slots 1 and 3 freed; spawns fill 1 then 3.
    kill = 4'b1010;
    cyc();
    kill = 4'b0000;
    idle(1);
    @(negedge clk);
    chk("two_free_active", {36'd0, active}, 40'd5);
    x_in = 10'd61; push(1, 10'd61); ticks(2); idle(2);
    @(negedge clk);
    chk("lowest_first", {36'd0, active}, 40'd7);
    x_in = 10'd62; push(3, 10'd62); ticks(3); idle(2);
    @(negedge clk);
    chk("lowest_second", {36'd0, active}, 40'd15);
    chk("lowest_x1",     {30'd0, ex(1)},  40'd61);
    chk("lowest_x3",     {30'd0, ex(3)},  40'd62);
    chk("lowest_y0",     {30'd0, ey(0)},  40'd36);

    // Kill takes priority over movement near the bottom.
    spawn_en = 1'b0;
    kill = 4'b1110;
    cyc();
    kill = 4'b0000;
    ticks(217);
    @(negedge clk);
    chk("near_bottom_active", {36'd0, active}, 40'd1);
    chk("near_bottom_y",      {30'd0, ey(0)},  40'd470);
    kill = 4'b0001; frame_tick = 1'b1;
    cyc();
    kill = 4'b0000; frame_tick = 1'b0;
    @(negedge clk);
    chk("kill_tick_active", {36'd0, active}, 40'd0);
    chk("kill_tick_y",      {30'd0, ey(0)},  40'd470);
    kill = 4'b0010;
    cyc();
    kill = 4'b0000;
    @(negedge clk);
    chk("kill_inactive", {36'd0, active}, 40'd0);

    // Reset during ADVANCE, with the timer advanced by a tick in the spawn cycle.
    spawn_en = 1'b1; x_in = 10'd77; push(0, 10'd77);
    ticks(2);
    frame_tick = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("advance_next", {39'd0, next}, 40'd1);
    cyc();
    reset = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    chk("mid_rst_next",    {39'd0, next},   40'd0);
    chk("mid_rst_active",  {36'd0, active}, 40'd0);
    chk("mid_rst_enemy_x", enemy_x,         40'd0);
    chk("mid_rst_enemy_y", enemy_y,         40'd0);

    // Timer restarted from 0: two ticks must not spawn, the third must.
    x_in = 10'd88;
    idle(3);
    ticks(2);
    idle(4);
    push(0, 10'd88);
    ticks(1);
    idle(4);
    @(negedge clk);
    chk("post_rst_active", {36'd0, active}, 40'd1);

    idle(5);
    chk("queue_empty", 40'(exp_q.size()), 40'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
